// File: rtl/light_pkg.sv
// Shared types for the light sequencer: state encoding, per-state ABC
// light patterns and the step-order helper.
package light_pkg;

    typedef enum logic [1:0] {
        ST_OFF = 2'b00,
        ST_S1  = 2'b01,
        ST_S2  = 2'b10,
        ST_S3  = 2'b11
    } light_state_e;

    localparam logic [2:0] ABC_OFF = 3'b000;
    localparam logic [2:0] ABC_S1  = 3'b100;
    localparam logic [2:0] ABC_S2  = 3'b110;
    localparam logic [2:0] ABC_S3  = 3'b111;

    function automatic logic [2:0] abc_of(input light_state_e s);
        logic [2:0] abc;
        case (s)
            ST_S1:   abc = ABC_S1;
            ST_S2:   abc = ABC_S2;
            ST_S3:   abc = ABC_S3;
            default: abc = ABC_OFF;
        endcase
        return abc;
    endfunction

    // S1 -> S2 -> S3 -> S1; OFF always enters at S1
    function automatic light_state_e next_step(input light_state_e s);
        light_state_e n;
        case (s)
            ST_S1:   n = ST_S2;
            ST_S2:   n = ST_S3;
            default: n = ST_S1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/light_dwell_timer.sv
// Dwell counter for the light sequencer: counts while enabled, clears on
// request, and flags when the programmed dwell has been reached.
module light_dwell_timer #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_clr,
    input  logic               i_en,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic               o_expired_c
);

    logic [DWELL_W-1:0] r_count;

    // Clear has priority so an advance always restarts the dwell from zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + DWELL_W'(1);
        end
    end

    assign o_expired_c = (r_count >= i_dwell);

endmodule

// File: rtl/light_seq_ctrl.sv
// Light sequencer: OFF/S1/S2/S3 with timed auto-advance and, when
// LIGHT_SEQ_MANUAL_EN is defined, a step_req/step_ack manual-step handshake.
module light_seq_ctrl
    import light_pkg::*;
#(
    parameter int unsigned DWELL_W      = 8,
    parameter bit          RST_STATE_ON = 1'b0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               on,
    input  logic               auto_en,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               step_req,
    output logic               step_ack,
    output logic               A,
    output logic               B,
    output logic               C,
    output logic [1:0]         state
);

    light_state_e r_state;
    light_state_e w_state_nxt;
    logic [2:0]   r_abc;
    logic         r_ack;
    logic         w_ack_nxt;
    logic         r_boot;
    logic         w_clr;
    logic         w_tmr_en;
    logic         w_expired_c;
    logic         w_man;
    logic         w_adv;
`ifdef LIGHT_SEQ_MANUAL_EN
    logic         r_lock;
    logic         w_lock_nxt;
`else
    logic         w_unused_step_req;
    assign w_unused_step_req = step_req;
`endif

    assign w_tmr_en = on && auto_en && (r_state != ST_OFF);

    light_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_clr       (w_clr),
        .i_en        (w_tmr_en),
        .i_dwell     (dwell),
        .o_expired_c (w_expired_c)
    );

    // Next-state, counter clear and handshake decisions
    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_ack_nxt   = 1'b0;
        w_man       = 1'b0;
        w_adv       = 1'b0;
`ifdef LIGHT_SEQ_MANUAL_EN
        w_man      = on && step_req && !r_lock && (r_state != ST_OFF);
        // Lockout holds after an ack until step_req is seen low
        w_lock_nxt = w_man || (r_lock && step_req);
`endif
        if (!on) begin
            w_state_nxt = ST_OFF;
            w_clr       = 1'b1;
        end else if (r_state == ST_OFF) begin
            w_clr       = 1'b1;
            // Without RST_STATE_ON the first post-reset cycle stays in OFF
            w_state_nxt = (r_boot && (RST_STATE_ON == 1'b0)) ? ST_OFF : ST_S1;
        end else begin
            w_adv = (auto_en && w_expired_c) || w_man;
            if (w_adv) begin
                w_state_nxt = next_step(r_state);
                w_clr       = 1'b1;
            end
            w_ack_nxt = w_man;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_OFF;
            r_abc   <= ABC_OFF;
            r_ack   <= 1'b0;
            r_boot  <= 1'b1;
`ifdef LIGHT_SEQ_MANUAL_EN
            r_lock  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_abc   <= abc_of(w_state_nxt);
            r_ack   <= w_ack_nxt;
            r_boot  <= 1'b0;
`ifdef LIGHT_SEQ_MANUAL_EN
            r_lock  <= w_lock_nxt;
`endif
        end
    end

    assign state     = r_state;
    assign {A, B, C} = r_abc;
    assign step_ack  = r_ack;

endmodule

// File: tb/tb_light_seq_ctrl.sv
// Directed self-checking bench for light_seq_ctrl (default parameters);
// manual-step checks are included when LIGHT_SEQ_MANUAL_EN is defined.
module tb_light_seq_ctrl;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          on;
    logic          auto_en;
    logic [DW-1:0] dwell;
    logic          step_req;
    logic          step_ack;
    logic          A, B, C;
    logic [1:0]    state;

    int n_chk  = 0;
    int n_pass = 0;

    light_seq_ctrl #(
        .DWELL_W      (DW),
        .RST_STATE_ON (1'b0)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .on       (on),
        .auto_en  (auto_en),
        .dwell    (dwell),
        .step_req (step_req),
        .step_ack (step_ack),
        .A        (A),
        .B        (B),
        .C        (C),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [2:0] abc_for(input logic [1:0] st);
        case (st)
            2'b01:   return 3'b100;
            2'b10:   return 3'b110;
            2'b11:   return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    task automatic check_out(input string tag, input logic [1:0] st, input logic ack);
        check_eq({tag, "/state"}, 32'(state), 32'(st));
        check_eq({tag, "/abc"}, 32'({A, B, C}), 32'(abc_for(st)));
        check_eq({tag, "/ack"}, 32'(step_ack), 32'(ack));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] seq [3];
        logic [1:0] prev;
        int         n_ack;
        seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b01;

        reset_n = 1'b0; on = 1'b1; auto_en = 1'b0; dwell = DW'(3); step_req = 1'b0;
        #12;
        check_out("in_reset", 2'b00, 1'b0);
        reset_n = 1'b1;
        tick();
        check_out("boot_cycle", 2'b00, 1'b0);
        tick();
        check_out("enter_s1", 2'b01, 1'b0);

`ifdef LIGHT_SEQ_MANUAL_EN
        step_req = 1'b1;
        n_ack = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_ack += int'(step_ack);
        end
        check_eq("hold_ack_count", 32'(n_ack), 32'd1);
        check_eq("hold_state", 32'(state), 32'd2);
        step_req = 1'b0;
        tick();
        check_out("req_dropped", 2'b10, 1'b0);
        step_req = 1'b1;
        tick();
        check_out("req_again", 2'b11, 1'b1);
        tick();
        check_out("req_again_held", 2'b11, 1'b0);
        step_req = 1'b0;
        tick();
        step_req = 1'b1;
        tick();
        check_out("req_wrap", 2'b01, 1'b1);
        step_req = 1'b0;
        tick();
`else
        for (int i = 0; i < 6; i++) begin
            step_req = ~step_req;
            tick();
            check_out("no_manual", 2'b01, 1'b0);
        end
        step_req = 1'b0;
`endif

        // dwell=3: four cycles per state, wrapping S3 -> S1
        auto_en = 1'b1;
        prev = 2'b01;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 3; i++) begin
                tick();
                check_eq("dwell3_hold", 32'(state), 32'(prev));
            end
            tick();
            check_out("dwell3_adv", seq[k], 1'b0);
            prev = seq[k];
        end

        dwell = DW'(0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_out("dwell0_adv", seq[k], 1'b0);
        end

        // lowering dwell below the running count advances on the next edge
        dwell = DW'(5);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("dwell5_hold", 32'(state), 32'd1);
        end
        dwell = DW'(1);
        tick();
        check_out("dwell_lowered", 2'b10, 1'b0);
        dwell = DW'(0);
        tick();
        check_out("to_s3", 2'b11, 1'b0);
        auto_en = 1'b0;
        dwell = DW'(3);

        on = 1'b0; step_req = 1'b1;
        tick();
        check_out("on_low", 2'b00, 1'b0);
        tick();
        check_out("on_low_hold", 2'b00, 1'b0);
        on = 1'b1;
        tick();
        check_out("on_high", 2'b01, 1'b0);
        tick();
`ifdef LIGHT_SEQ_MANUAL_EN
        check_out("served_from_s1", 2'b10, 1'b1);
        step_req = 1'b0;
        tick();
        // auto and manual advance on the same edge
        auto_en = 1'b1; dwell = DW'(2);
        tick();
        tick();
        check_eq("cnt2_hold", 32'(state), 32'd2);
        step_req = 1'b1;
        tick();
        check_out("auto_and_manual", 2'b11, 1'b1);
        step_req = 1'b0;
        tick();
        check_out("after_both_1", 2'b11, 1'b0);
        tick();
        check_out("after_both_2", 2'b11, 1'b0);
        tick();
        check_out("after_both_adv", 2'b01, 1'b0);
        auto_en = 1'b0;
        step_req = 1'b1;
        tick();
        check_out("pre_reset_ack", 2'b10, 1'b1);
`else
        check_out("req_ignored", 2'b01, 1'b0);
        step_req = 1'b0;
        tick();
        check_out("req_ignored_2", 2'b01, 1'b0);
`endif

        #2;
        reset_n = 1'b0;
        #1;
        check_out("async_reset", 2'b00, 1'b0);
        #10;
        reset_n = 1'b1;
        step_req = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
